// File: rtl/conv_out_collector.sv
// Collects convolver results under ce backpressure, tags them with output row/col
// and replays them on a valid/ready stream through a FWFT FIFO. Optional ReLU: RELU_EN.
module conv_out_collector #(
  parameter int unsigned MAP_SIZE  = 10,
  parameter int unsigned k         = 3,
  parameter int unsigned s         = 1,
  parameter int unsigned N         = 8,
  parameter int unsigned Q         = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned HEADROOM  = 2,
  localparam int unsigned OUT_W     = (MAP_SIZE - k) / s + 1,
  localparam int unsigned TOTAL_OUT = OUT_W * OUT_W,
  localparam int unsigned CW        = $clog2(OUT_W)
) (
  input  logic          clk,
  input  logic          global_rst,
  input  logic          start,
  input  logic [N-1:0]  conv_op,
  input  logic          valid_conv,
  input  logic          end_conv,
  output logic          ce_req,
  output logic [N-1:0]  m_data,
  output logic [CW-1:0] m_row,
  output logic [CW-1:0] m_col,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          frame_done,
  output logic          frame_err
);

  localparam int unsigned EW = N + 2 * CW + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(TOTAL_OUT + 1);

  // Q only labels the fixed-point format; data passes through without rescale.
  if (Q >= N) begin : g_q_exceeds_width
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] count_q, count_d, free_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [AW-1:0] acc_cnt_q, acc_cnt_d;
  logic          ce_req_q, ce_req_d;
  logic          err_q, err_d;

  logic          acc, is_last, full, push, pop;
  logic [N-1:0]  push_data;
  logic [EW-1:0] push_entry, rd_entry;

`ifdef RELU_EN
  assign push_data = conv_op[N-1] ? '0 : conv_op;
`else
  assign push_data = conv_op;
`endif

  assign acc        = valid_conv & ce_req_q & (state_q == S_COLLECT);
  assign is_last    = (acc_cnt_q == AW'(TOTAL_OUT - 1));
  assign full       = (count_q == FW'(DEPTH));
  assign m_valid    = (count_q != '0);
  assign pop        = m_valid & m_ready;
  assign push       = acc & (~full | pop);
  assign push_entry = {push_data, row_q, col_q, is_last | end_conv};
  assign rd_entry   = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    row_d     = row_q;
    col_d     = col_q;
    acc_cnt_d = acc_cnt_q;
    err_d     = err_q;
    ce_req_d  = 1'b0;
    free_d    = '0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_COLLECT;
          row_d     = '0;
          col_d     = '0;
          acc_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      S_COLLECT: begin
        if (acc) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (col_q == CW'(OUT_W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (!push) err_d = 1'b1;
          // Either an early end_conv or a missing one ends the frame with an error.
          if (end_conv) begin
            if (!is_last) err_d = 1'b1;
            state_d = S_DRAIN;
          end else if (is_last) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (count_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered ce_req looks at the post-update fill so one in-flight accept still fits.
    free_d = FW'(DEPTH) - count_d;
    if (state_d == S_COLLECT) ce_req_d = (free_d > FW'(HEADROOM));
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      acc_cnt_q <= '0;
      ce_req_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      row_q     <= row_d;
      col_q     <= col_d;
      acc_cnt_q <= acc_cnt_d;
      ce_req_q  <= ce_req_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign m_data     = m_valid ? rd_entry[EW-1 -: N]  : '0;
  assign m_row      = m_valid ? rd_entry[2*CW -: CW] : '0;
  assign m_col      = m_valid ? rd_entry[CW -: CW]   : '0;
  assign m_last     = m_valid & rd_entry[0];
  assign ce_req     = ce_req_q;
  assign frame_done = (state_q == S_DONE);
  assign frame_err  = err_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector: expected outputs queued per accepted result.
module tb_conv_out_collector;

  logic       clk = 1'b0;
  logic       global_rst, start, valid_conv, end_conv, m_ready;
  logic [7:0] conv_op;
  logic       ce_req, m_last, m_valid, frame_done, frame_err;
  logic [7:0] m_data;
  logic [2:0] m_row, m_col;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned n_out = 0;
  int unsigned idx = 0;
  logic [14:0] exp_q [$];

  always #5 clk = ~clk;

  conv_out_collector dut (
    .clk(clk), .global_rst(global_rst), .start(start), .conv_op(conv_op),
    .valid_conv(valid_conv), .end_conv(end_conv), .ce_req(ce_req),
    .m_data(m_data), .m_row(m_row), .m_col(m_col), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  function automatic logic [7:0] relu(input logic [7:0] d);
`ifdef RELU_EN
    return d[7] ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    idx = 0;
    check("ce_after_start", ce_req, 1);
  endtask

  // Models a convolver frozen by ce: the result stays presented until accepted.
  task automatic send(input logic [7:0] d, input logic e);
    int unsigned w;
    w = 0;
    conv_op = d; end_conv = e; valid_conv = 1'b1;
    while (!ce_req && w < 200) begin
      step();
      w++;
    end
    check("ce_req_wait", ce_req, 1);
    exp_q.push_back({relu(d), 3'(idx / 8), 3'(idx % 8), (idx == 63) || e});
    idx++;
    step();
    valid_conv = 1'b0; end_conv = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned w;
    w = 0;
    while (!frame_done && w < 100) begin
      step();
      w++;
    end
    check(tag, frame_done, 1);
    check("queue_empty_at_done", exp_q.size(), 0);
    step();
    check("done_one_cycle", frame_done, 0);
  endtask

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      check("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("out_data_row_col_last", {m_data, m_row, m_col, m_last}, exp_q.pop_front());
        n_out++;
      end
    end
  end

  initial begin
    global_rst = 1'b1; start = 1'b0; valid_conv = 1'b0; end_conv = 1'b0;
    m_ready = 1'b0; conv_op = 8'h00;
    step(); step();
    global_rst = 1'b0;
    check("rst_ce_req", ce_req, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    step();
    check("idle_ce_req", ce_req, 0);

    // T1: full frame, consumer always ready
    m_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 64; i++) send(8'(i * 5 + 3), i == 63);
    check("t1_last_head", m_last, 1);
    check("t1_done_a0", frame_done, 0);
    step(); check("t1_done_a1", frame_done, 0);
    step(); check("t1_done_a2", frame_done, 1);
    step(); check("t1_done_a3", frame_done, 0);
    check("t1_err", frame_err, 0);
    check("t1_outputs", n_out, 64);

    // T2/T3: stalled consumer, ce_req backpressure, held result captured once
    m_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 14; i++) begin
      if (i == 13) check("t2_ce_before_14", ce_req, 1);
      send(8'(8'h40 + i), 1'b0);
    end
    check("t2_ce_dropped", ce_req, 0);
    conv_op = 8'h12; valid_conv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_ce_held_low", ce_req, 0);
    end
    check("t2_no_pop_yet", n_out, 64);
    m_ready = 1'b1;
    send(8'h12, 1'b0);
    for (int i = 15; i < 64; i++) send(8'(8'h40 + i), i == 63);
    wait_done("t2_done");
    check("t2_err", frame_err, 0);
    check("t2_outputs", n_out, 128);

    // T4: early end_conv on the 10th accept
    start_frame();
    for (int i = 0; i < 10; i++) send(8'(8'hA0 + i), i == 9);
    wait_done("t4_done");
    check("t4_err", frame_err, 1);
    check("t4_outputs", n_out, 138);
    step();
    check("t4_err_sticky", frame_err, 1);

    // T5: reset mid-frame with 5 buffered entries
    m_ready = 1'b0;
    start_frame();
    check("t5_err_cleared", frame_err, 0);
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b0);
    check("t5_holding", m_valid, 1);
    global_rst = 1'b1;
    step();
    global_rst = 1'b0;
    exp_q.delete();
    check("t5_m_valid", m_valid, 0);
    check("t5_ce_req", ce_req, 0);
    check("t5_err", frame_err, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_no_done", frame_done, 0);
      check("t5_empty", m_valid, 0);
    end

    // T6: new frame after reset, ReLU-sensitive leading values
    start_frame();
    send(8'hF0, 1'b0);
    send(8'h23, 1'b0);
    for (int i = 2; i < 64; i++) send(8'(8'h80 + i * 3), i == 63);
    wait_done("t6_done");
    check("t6_err", frame_err, 0);
    check("final_outputs", n_out, 202);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
